// File: rtl/sr_trace_monitor.sv
// sr_trace_monitor
//
// Execution-trace monitor for the schoolRISCV core. While the CPU runs it
// records {fetch PC, instruction, watched register} into a circular history
// buffer. It freezes when the program halts (PC repeats STALL_LIMIT times)
// or when a cycle budget runs out. After freezing it streams the history
// out, oldest entry first, over a valid/ready port.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sample_en       qualifies pc_i / instr_i / watch_i
//   pc_i            current fetch PC
//   instr_i         current instruction
//   watch_i         watched register value (normally a0)
//   dump_start      request a stream-out (HALT, TIMEOUT, DONE only)
//   dump_ready      sink accepts the current beat
//   dump_valid      beat present
//   dump_pc/instr/watch  beat payload
//   dump_last       final beat of the stream
//   state_o         RUN=0, HALT=1, TIMEOUT=2, DUMP=3, DONE=4
//   halt_o          sticky halt flag
//   timeout_o       sticky timeout flag
//   cycle_o         clocks spent in RUN since reset
//   count_o         valid entries in the buffer

module sr_trace_monitor #(
    parameter int DEPTH          = 16,
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STALL_LIMIT    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [PC_WIDTH-1:0]     pc_i,
    input  logic [DATA_WIDTH-1:0]   instr_i,
    input  logic [DATA_WIDTH-1:0]   watch_i,
    input  logic                    dump_start,
    input  logic                    dump_ready,
    output logic                    dump_valid,
    output logic [PC_WIDTH-1:0]     dump_pc,
    output logic [DATA_WIDTH-1:0]   dump_instr,
    output logic [DATA_WIDTH-1:0]   dump_watch,
    output logic                    dump_last,
    output logic [2:0]              state_o,
    output logic                    halt_o,
    output logic                    timeout_o,
    output logic [31:0]             cycle_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_HALT    = 3'd1,
        ST_TIMEOUT = 3'd2,
        ST_DUMP    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         remaining_q, remaining_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [31:0]           stall_q, stall_d;
    logic [PC_WIDTH-1:0]   prevPc_q, prevPc_d;
    logic                  havePrev_q, havePrev_d;
    logic                  halt_q, halt_d;
    logic                  timeout_q, timeout_d;

    logic                  doWrite;
    logic [31:0]           cycleInc;
    logic [31:0]           stallNext;

    logic [PC_WIDTH-1:0]   pcMem    [DEPTH];
    logic [DATA_WIDTH-1:0] instrMem [DEPTH];
    logic [DATA_WIDTH-1:0] watchMem [DEPTH];

    // Next-state and datapath control for the whole monitor.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        cycle_d     = cycle_q;
        stall_d     = stall_q;
        prevPc_d    = prevPc_q;
        havePrev_d  = havePrev_q;
        halt_d      = halt_q;
        timeout_d   = timeout_q;
        doWrite     = 1'b0;
        cycleInc    = cycle_q + 32'd1;
        stallNext   = '0;

        case (state_q)
            ST_RUN: begin
                cycle_d = cycleInc;
                if (sample_en) begin
                    doWrite    = 1'b1;
                    wrPtr_d    = wrPtr_q + AW'(1);
                    if (count_q != CW'(DEPTH)) begin
                        count_d = count_q + CW'(1);
                    end
                    // The first sample after reset has no predecessor to match.
                    stallNext  = (havePrev_q && (pc_i == prevPc_q)) ? stall_q + 32'd1 : 32'd0;
                    stall_d    = stallNext;
                    prevPc_d   = pc_i;
                    havePrev_d = 1'b1;
                end
                // Halt takes priority over a timeout on the same edge.
                if (sample_en && (stallNext >= 32'(STALL_LIMIT))) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (cycleInc == 32'(TIMEOUT_CYCLES))) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end

            ST_HALT, ST_TIMEOUT, ST_DONE: begin
                if (dump_start) begin
                    state_d     = ST_DUMP;
                    // Oldest entry; a full buffer wraps back onto wrPtr itself.
                    rdPtr_d     = wrPtr_q - count_q[AW-1:0];
                    remaining_d = count_q;
                end
            end

            ST_DUMP: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else if (dump_ready) begin
                    rdPtr_d     = rdPtr_q + AW'(1);
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            cycle_q     <= '0;
            stall_q     <= '0;
            prevPc_q    <= '0;
            havePrev_q  <= 1'b0;
            halt_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            cycle_q     <= cycle_d;
            stall_q     <= stall_d;
            prevPc_q    <= prevPc_d;
            havePrev_q  <= havePrev_d;
            halt_q      <= halt_d;
            timeout_q   <= timeout_d;
        end
    end

    // History buffer; contents are left alone by reset.
    always_ff @(posedge clk) begin
        if (doWrite && !rst) begin
            pcMem[wrPtr_q]    <= pc_i;
            instrMem[wrPtr_q] <= instr_i;
            watchMem[wrPtr_q] <= watch_i;
        end
    end

    assign dump_valid = (state_q == ST_DUMP) && (remaining_q != '0);
    assign dump_last  = dump_valid && (remaining_q == CW'(1));
    assign dump_pc    = pcMem[rdPtr_q];
    assign dump_instr = instrMem[rdPtr_q];
    assign dump_watch = watchMem[rdPtr_q];
    assign state_o    = state_q;
    assign halt_o     = halt_q;
    assign timeout_o  = timeout_q;
    assign cycle_o    = cycle_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_sr_trace_monitor.sv
// tb_sr_trace_monitor
//
// Directed bench for sr_trace_monitor. Two instances share every input:
// instance 0 has no timeout (halt scenarios), instance 1 times out after
// 20 RUN clocks (timeout and empty-buffer scenarios). Both use DEPTH=8 and
// STALL_LIMIT=3. Inputs change 1 time unit after the rising edge and outputs
// are sampled at the same point.

module tb_sr_trace_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic [31:0] watch_i;
    logic        dump_start;
    logic        dump_ready;

    logic        dValid   [2];
    logic [31:0] dPc      [2];
    logic [31:0] dInstr   [2];
    logic [31:0] dWatch   [2];
    logic        dLast    [2];
    logic [2:0]  st       [2];
    logic        haltF    [2];
    logic        timeoutF [2];
    logic [31:0] cyc      [2];
    logic [3:0]  cnt      [2];

    logic [31:0] expPcs [8];

    int assertCount = 0;
    int failCount   = 0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    sr_trace_monitor #(
        .DEPTH(8), .PC_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0), .STALL_LIMIT(3)
    ) dutHalt (
        .clk(clk), .rst(rst), .sample_en(sample_en), .pc_i(pc_i), .instr_i(instr_i),
        .watch_i(watch_i), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dValid[0]), .dump_pc(dPc[0]), .dump_instr(dInstr[0]),
        .dump_watch(dWatch[0]), .dump_last(dLast[0]), .state_o(st[0]),
        .halt_o(haltF[0]), .timeout_o(timeoutF[0]), .cycle_o(cyc[0]), .count_o(cnt[0])
    );

    sr_trace_monitor #(
        .DEPTH(8), .PC_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(20), .STALL_LIMIT(3)
    ) dutTimeout (
        .clk(clk), .rst(rst), .sample_en(sample_en), .pc_i(pc_i), .instr_i(instr_i),
        .watch_i(watch_i), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dValid[1]), .dump_pc(dPc[1]), .dump_instr(dInstr[1]),
        .dump_watch(dWatch[1]), .dump_last(dLast[1]), .state_o(st[1]),
        .halt_o(haltF[1]), .timeout_o(timeoutF[1]), .cycle_o(cyc[1]), .count_o(cnt[1])
    );

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one sample (or an idle cycle) and clock it in.
    task automatic applyStimulus(input logic en, input logic [31:0] pc);
        sample_en = en;
        pc_i      = pc;
        instr_i   = pc ^ 32'hA5A5_0000;
        watch_i   = pc + 32'h100;
        tick();
        sample_en = 1'b0;
    endtask

    // Two reset clocks with sample_en toggling underneath.
    task automatic doReset();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        rst        = 1'b1;
        sample_en  = 1'b1;
        pc_i       = 32'hDEAD_0000;
        tick();
        sample_en  = 1'b0;
        tick();
        rst        = 1'b0;
    endtask

    // Start a dump on instance d and check the stream against expPcs.
    // stallBeat selects a beat at which dump_ready is dropped for 3 cycles.
    task automatic runDump(input string tag, input int d, input int stallBeat, input int expN);
        int beat      = 0;
        int dumpCyc   = 0;
        int stallLeft = 3;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        checkOutput({tag, "_enter"}, 64'(st[d]), 64'd3);
        while (st[d] == 3'd3 && dumpCyc < 40) begin
            dump_ready = !(beat == stallBeat && stallLeft > 0);
            if (dValid[d]) begin
                if (beat >= expN) begin
                    checkOutput({tag, "_extra_beat"}, 64'(beat), 64'(expN - 1));
                end else if (dump_ready) begin
                    checkOutput({tag, "_pc"}, 64'(dPc[d]), 64'(expPcs[beat]));
                    checkOutput({tag, "_instr"}, 64'(dInstr[d]), 64'(expPcs[beat] ^ 32'hA5A5_0000));
                    checkOutput({tag, "_watch"}, 64'(dWatch[d]), 64'(expPcs[beat] + 32'h100));
                    checkOutput({tag, "_last"}, 64'(dLast[d]), 64'(beat == expN - 1));
                    beat++;
                end else begin
                    checkOutput({tag, "_hold_pc"}, 64'(dPc[d]), 64'(expPcs[beat]));
                    checkOutput({tag, "_hold_last"}, 64'(dLast[d]), 64'(beat == expN - 1));
                    stallLeft--;
                end
            end
            tick();
            dumpCyc++;
        end
        dump_ready = 1'b1;
        checkOutput({tag, "_beats"}, 64'(beat), 64'(expN));
        checkOutput({tag, "_done"}, 64'(st[d]), 64'd4);
        checkOutput({tag, "_valid_after"}, 64'(dValid[d]), 64'd0);
        if (expN == 0) begin
            checkOutput({tag, "_empty_cycles"}, 64'(dumpCyc), 64'd1);
        end
    endtask

    // Overall time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        rst = 1'b1; sample_en = 1'b0; pc_i = '0; instr_i = '0; watch_i = '0;
        dump_start = 1'b0; dump_ready = 1'b1;

        // Reset state, then the first sample.
        doReset();
        checkOutput("rst_state", 64'(st[0]), 64'd0);
        checkOutput("rst_count", 64'(cnt[0]), 64'd0);
        checkOutput("rst_cycle", 64'(cyc[0]), 64'd0);
        checkOutput("rst_halt", 64'(haltF[0]), 64'd0);
        checkOutput("rst_timeout", 64'(timeoutF[0]), 64'd0);
        checkOutput("rst_valid", 64'(dValid[0]), 64'd0);
        checkOutput("rst_last", 64'(dLast[0]), 64'd0);
        applyStimulus(1'b1, 32'd0);
        checkOutput("first_count", 64'(cnt[0]), 64'd1);

        // Halt: pcs 0,4,8,12,16,20,20,20,20.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'(4 * i));
        applyStimulus(1'b1, 32'd20);
        applyStimulus(1'b1, 32'd20);
        checkOutput("pre_halt_state", 64'(st[0]), 64'd0);
        checkOutput("pre_halt_flag", 64'(haltF[0]), 64'd0);
        applyStimulus(1'b1, 32'd20);
        checkOutput("halt_state", 64'(st[0]), 64'd1);
        checkOutput("halt_flag", 64'(haltF[0]), 64'd1);
        checkOutput("halt_timeout_flag", 64'(timeoutF[0]), 64'd0);
        checkOutput("halt_count", 64'(cnt[0]), 64'd8);
        checkOutput("halt_cycle", 64'(cyc[0]), 64'd9);
        applyStimulus(1'b1, 32'd99);
        checkOutput("halt_frozen_count", 64'(cnt[0]), 64'd8);
        checkOutput("halt_frozen_cycle", 64'(cyc[0]), 64'd9);

        expPcs = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd20, 32'd20, 32'd20};
        runDump("halt_dump", 0, -1, 8);
        checkOutput("dump_cycle_hold", 64'(cyc[0]), 64'd9);
        // Backpressure on beat 2, then a clean replay from DONE.
        runDump("bp_dump", 0, 2, 8);
        runDump("replay_dump", 0, -1, 8);

        // Timeout with distinct pcs every cycle.
        doReset();
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 32'h100 + 32'(4 * i));
        checkOutput("pre_to_state", 64'(st[1]), 64'd0);
        checkOutput("pre_to_cycle", 64'(cyc[1]), 64'd19);
        applyStimulus(1'b1, 32'h100 + 32'(4 * 19));
        checkOutput("to_state", 64'(st[1]), 64'd2);
        checkOutput("to_cycle", 64'(cyc[1]), 64'd20);
        checkOutput("to_flag", 64'(timeoutF[1]), 64'd1);
        checkOutput("to_halt_flag", 64'(haltF[1]), 64'd0);
        checkOutput("to_count", 64'(cnt[1]), 64'd8);
        checkOutput("nohalt_inst0", 64'(st[0]), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h900 + 32'(4 * i));
        checkOutput("to_frozen_cycle", 64'(cyc[1]), 64'd20);
        checkOutput("to_frozen_state", 64'(st[1]), 64'd2);
        for (int k = 0; k < 8; k++) expPcs[k] = 32'h100 + 32'(4 * (12 + k));
        runDump("to_dump", 1, -1, 8);

        // Empty buffer: timeout without any samples.
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("empty_state", 64'(st[1]), 64'd2);
        checkOutput("empty_count", 64'(cnt[1]), 64'd0);
        runDump("empty_dump", 1, -1, 0);

        // Reset in the middle of a dump.
        doReset();
        applyStimulus(1'b1, 32'd0);
        applyStimulus(1'b1, 32'd4);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd8);
        checkOutput("mid_halt_state", 64'(st[0]), 64'd1);
        checkOutput("mid_halt_count", 64'(cnt[0]), 64'd6);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        tick();
        checkOutput("mid_third_pc", 64'(dPc[0]), 64'd8);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_state", 64'(st[0]), 64'd0);
        checkOutput("mid_rst_valid", 64'(dValid[0]), 64'd0);
        checkOutput("mid_rst_count", 64'(cnt[0]), 64'd0);
        checkOutput("mid_rst_cycle", 64'(cyc[0]), 64'd0);
        checkOutput("mid_rst_halt", 64'(haltF[0]), 64'd0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
